disparity_pace_mapper: RTL and testbench
========================================

# disparity_pace_mapper

Downstream consumer of `stereo_match`'s SSD result BRAM. When `stereo_match` signals frame completion, the block scans a rectangular region of interest (ROI) of the disparity map through the `external_ssd_addr`/`ssd_dout` read port. It averages the valid disparities and maps the mean to the 4-bit pace speed driving `led_top`, which closes the `UPDATE_LED` path in the top-level FSM. It also reports the mean disparity and the valid-pixel count for `bram_readout`/debug.

## Interface
Parameters:
- `WIDTH`, 320, disparity map width in pixels
- `HEIGHT`, 240, disparity map height in pixels
- `ADDR_W`, 17, BRAM address width ($clog2(WIDTH*HEIGHT))
- `DISP_W`, 8, disparity width
- `X0`, 0 / `X1`, 319, inclusive ROI column bounds; X0 ≤ X1 < WIDTH
- `Y0`, 0 / `Y1`, 239, inclusive ROI row bounds; Y0 ≤ Y1 < HEIGHT
- `MIN_DISP`, 1, disparities below this are invalid (unmatched/background)
- `MIN_COUNT`, 64, fewest valid pixels required for a depth estimate
- `READ_LATENCY`, 2, BRAM address-to-data latency in cycles

Ports:
- `clk_in` input 1 system clock
- `rst_in` input 1 reset; one clock domain, reset is asynchronous and active-high
- `start_in` input 1 pulse; connect to `stereo_match` `new_frame_out`
- `rd_addr_out` output ADDR_W SSD BRAM read address
- `disp_in` input DISP_W BRAM read data, valid READ_LATENCY cycles after the address
- `busy_out` output 1 high in any state except IDLE
- `done_out` output 1 one-cycle pulse when results update
- `mean_disp_out` output DISP_W truncated mean of valid disparities
- `valid_count_out` output ADDR_W number of valid ROI pixels
- `depth_valid_out` output 1 count ≥ MIN_COUNT for the latest frame
- `speed_out` output 4 pace speed for `led_top`

## Operation
- States: IDLE → SCAN → DRAIN → DIVIDE → MAP → IDLE.
- IDLE: `start_in` high loads x=X0, y=Y0, `rd_addr_out`=Y0*WIDTH+X0, and clears the accumulators. Next state is SCAN.
- SCAN: issues one address per cycle in raster order (x fastest). `rd_addr_out` = y*WIDTH + x, computed incrementally (+1 per pixel, +WIDTH−(X1−X0) at row wrap) with no multiplier. After address Y1*WIDTH+X1 is issued, the next state is DRAIN.
- Capture: a READ_LATENCY-deep shift register of issue flags qualifies `disp_in`. Each qualified sample ≥ MIN_DISP adds to `sum` (ADDR_W+DISP_W = 25 bits, cannot overflow) and increments `count`.
- DRAIN: READ_LATENCY+1 cycles so the last sample is accumulated, then DIVIDE.
- DIVIDE: restoring divider computing sum/count, 1 quotient bit per cycle, 25 cycles, truncating. It runs even if count=0; the result is then discarded.
- MAP, single cycle:
  - If count ≥ MIN_COUNT: `mean_disp_out`=quotient[7:0], where quotient ≤255 is guaranteed. `speed_out`=max(1, mean[7:4]). `depth_valid_out`=1.
  - Otherwise: `mean_disp_out`=0 and `depth_valid_out`=0. `speed_out` holds its previous value.
  - In both cases `valid_count_out`=count.
- `done_out` pulses the cycle after MAP. All result outputs are registered and change only in that cycle.
- `start_in` is ignored while `busy_out` is high; it is not queued.
- Reset, including mid-operation: state IDLE. All outputs 0: `rd_addr_out`, `busy_out`, `done_out`, `mean_disp_out`, `valid_count_out`, `depth_valid_out`, `speed_out`. Accumulators and the pipeline are cleared. Reads in flight are discarded.

## Timing
- N = (X1−X0+1)*(Y1−Y0+1).
- Start sampled at edge 0. First address is presented after edge 0. Last address is presented after edge N−1.
- `busy_out` rises after edge 0 and falls on the same edge that raises `done_out`.
- `done_out` is high exactly N + READ_LATENCY + 28 cycles after edge 0, for one cycle.
- The earliest accepted new start is the cycle `done_out` is high, since the state is IDLE then.
- ROI of one pixel (N=1) is legal: SCAN lasts 1 cycle.
- Row wrap and frame end on the same pixel (x=X1, y=Y1) go to DRAIN; no wrap address is issued.

## Test plan
- ROI 4×2 at X0=10,Y0=5, MIN_COUNT=1, all disparities 40 → addresses 1610–1613 then 1930–1933; count=8, mean=40, speed=2, valid=1. `done_out` at cycle 8+2+28=38.
- Same ROI, disparities 10,11,0,0,10,11,0,0 → count=4, sum=42, mean=10 (truncation), speed=1 (clamped), valid=1.
- MIN_COUNT=64, full 320×240 map with only 63 nonzero pixels of 200, previous speed=12 → valid=0, mean=0, count=63, speed stays 12.
- Second `start_in` pulse mid-SCAN → ignored. Exactly one `done_out`, and results match a single scan.
- Assert `rst_in` during DIVIDE → all outputs 0 immediately. A later start gives correct results with no leftover accumulation.
- Single-pixel ROI (X0=X1=319, Y0=Y1=239), disparity 255, MIN_COUNT=1 → address 76799; mean=255, speed=15, `done_out` at cycle 31.

Source files
------------

// File: rtl/disparity_pace_mapper_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// disparity_pace_mapper_if: frame start, SSD BRAM read port and result bus. Rev 1.0
//------------------------------------------------------------------------------
interface disparity_pace_mapper_if #(
    parameter int ADDR_W = 17,
    parameter int DISP_W = 8
);
    logic              start_in;
    logic [ADDR_W-1:0] rd_addr_out;
    logic [DISP_W-1:0] disp_in;
    logic              busy_out;
    logic              done_out;
    logic [DISP_W-1:0] mean_disp_out;
    logic [ADDR_W-1:0] valid_count_out;
    logic              depth_valid_out;
    logic [3:0]        speed_out;

    modport slave (
        input  start_in, disp_in,
        output rd_addr_out, busy_out, done_out, mean_disp_out,
               valid_count_out, depth_valid_out, speed_out
    );

    modport master (
        output start_in, disp_in,
        input  rd_addr_out, busy_out, done_out, mean_disp_out,
               valid_count_out, depth_valid_out, speed_out
    );
endinterface
`default_nettype wire

// File: rtl/disparity_pace_mapper.sv
`default_nettype none
//------------------------------------------------------------------------------
// disparity_pace_mapper: ROI disparity mean -> 4-bit LED pace speed. Rev 1.0
//------------------------------------------------------------------------------
module disparity_pace_mapper #(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int ADDR_W       = 17,
    parameter int DISP_W       = 8,
    parameter int X0           = 0,
    parameter int X1           = 319,
    parameter int Y0           = 0,
    parameter int Y1           = 239,
    parameter int MIN_DISP     = 1,
    parameter int MIN_COUNT    = 64,
    parameter int READ_LATENCY = 2
) (
    input  wire logic               clk_in,
    input  wire logic               rst_in,
    disparity_pace_mapper_if.slave  bus
);

    localparam int c_SUM_W    = ADDR_W + DISP_W;
    localparam int c_CNT_W    = 6;
    localparam int c_X_LAST   = (X1 < WIDTH)  ? X1 : WIDTH - 1;
    localparam int c_Y_LAST   = (Y1 < HEIGHT) ? Y1 : HEIGHT - 1;
    localparam int c_DISP_MAX = (2 ** DISP_W) - 1;

    localparam logic [ADDR_W-1:0]  c_ADDR_FIRST = ADDR_W'(Y0 * WIDTH + X0);
    localparam logic [ADDR_W-1:0]  c_ADDR_LAST  = ADDR_W'(c_Y_LAST * WIDTH + c_X_LAST);
    localparam logic [ADDR_W-1:0]  c_ROW_STEP   = ADDR_W'(WIDTH - (c_X_LAST - X0));
    localparam logic [ADDR_W-1:0]  c_X_START    = ADDR_W'(X0);
    localparam logic [ADDR_W-1:0]  c_X_END      = ADDR_W'(c_X_LAST);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(READ_LATENCY);
    // Cycle 0 of DIVIDE loads the operands, cycles 1..c_SUM_W each retire one quotient bit.
    localparam logic [c_CNT_W-1:0] c_DIV_LAST   = c_CNT_W'(c_SUM_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_DRAIN  = 3'd2,
        S_DIVIDE = 3'd3,
        S_MAP    = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [ADDR_W-1:0]         x_q, x_d;
    logic [c_CNT_W-1:0]        cnt_q, cnt_d;
    logic [READ_LATENCY-1:0]   pipe_q, pipe_d;
    logic [c_SUM_W-1:0]        sum_q;
    logic [ADDR_W-1:0]         count_q;
    logic [c_SUM_W-1:0]        rem_q;
    logic [c_SUM_W-1:0]        quo_q;
    logic [DISP_W-1:0]         mean_q;
    logic [ADDR_W-1:0]         vcount_q;
    logic                      dvalid_q;
    logic [3:0]                speed_q;
    logic                      done_q;

    logic                      w_take;
    logic [c_SUM_W:0]          w_shift;
    logic [c_SUM_W:0]          w_divisor;
    logic                      w_fits;
    logic [DISP_W-1:0]         w_mean;
    logic [3:0]                w_speed;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_in) begin
                    state_d = S_SCAN;
                    addr_d  = c_ADDR_FIRST;
                    x_d     = c_X_START;
                end
            end
            S_SCAN: begin
                // Frame end wins over row wrap so no address past the ROI is issued.
                if (addr_q == c_ADDR_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else if (x_q == c_X_END) begin
                    x_d    = c_X_START;
                    addr_d = addr_q + c_ROW_STEP;
                end else begin
                    x_d    = x_q + ADDR_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == c_DRAIN_LAST) begin
                    state_d = S_DIVIDE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_DIVIDE: begin
                if (cnt_q == c_DIV_LAST) begin
                    state_d = S_MAP;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_MAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = (state_q == S_SCAN);
    end

    assign w_take    = pipe_q[READ_LATENCY-1] && (bus.disp_in >= DISP_W'(MIN_DISP));
    assign w_shift   = {rem_q, quo_q[c_SUM_W-1]};
    assign w_divisor = (c_SUM_W + 1)'(count_q);
    assign w_fits    = (w_shift >= w_divisor);
    assign w_mean    = (quo_q > c_SUM_W'(c_DISP_MAX)) ? DISP_W'(c_DISP_MAX) : quo_q[DISP_W-1:0];
    assign w_speed   = (w_mean[DISP_W-1 -: 4] == 4'd0) ? 4'd1 : w_mean[DISP_W-1 -: 4];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pipe_q   <= '0;
            sum_q    <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            mean_q   <= '0;
            vcount_q <= '0;
            dvalid_q <= 1'b0;
            speed_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            pipe_q <= pipe_d;
            if ((state_q == S_IDLE) && bus.start_in) begin
                sum_q   <= '0;
                count_q <= '0;
            end else if (w_take) begin
                sum_q   <= sum_q + c_SUM_W'(bus.disp_in);
                count_q <= count_q + ADDR_W'(1);
            end

            if (state_q == S_DIVIDE) begin
                if (cnt_q == '0) begin
                    rem_q <= '0;
                    quo_q <= sum_q;
                end else if (w_fits) begin
                    rem_q <= c_SUM_W'(w_shift - w_divisor);
                    quo_q <= {quo_q[c_SUM_W-2:0], 1'b1};
                end else begin
                    rem_q <= c_SUM_W'(w_shift);
                    quo_q <= {quo_q[c_SUM_W-2:0], 1'b0};
                end
            end

            done_q <= (state_q == S_MAP);
            if (state_q == S_MAP) begin
                vcount_q <= count_q;
                if (count_q >= ADDR_W'(MIN_COUNT)) begin
                    mean_q   <= w_mean;
                    speed_q  <= w_speed;
                    dvalid_q <= 1'b1;
                end else begin
                    mean_q   <= '0;
                    dvalid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.rd_addr_out     = addr_q;
    assign bus.busy_out        = (state_q != S_IDLE);
    assign bus.done_out        = done_q;
    assign bus.mean_disp_out   = mean_q;
    assign bus.valid_count_out = vcount_q;
    assign bus.depth_valid_out = dvalid_q;
    assign bus.speed_out       = speed_q;

endmodule
`default_nettype wire

// File: tb/tb_disparity_pace_mapper.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_disparity_pace_mapper: directed scoreboard bench for disparity_pace_mapper. Rev 1.0
//------------------------------------------------------------------------------
module tb_disparity_pace_mapper;

    localparam int AW = 17;
    localparam int DW = 8;

    typedef struct {
        int mean;
        int count;
        int dv;
        int speed;
        int cyc;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    int unsigned cyc    = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        q_c[$];
    logic [7:0]  mem [0:76799];
    logic [7:0]  a_p1, b_p1, c_p1;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    disparity_pace_mapper_if #(.ADDR_W(AW), .DISP_W(DW)) bus_a ();
    disparity_pace_mapper_if #(.ADDR_W(AW), .DISP_W(DW)) bus_b ();
    disparity_pace_mapper_if #(.ADDR_W(AW), .DISP_W(DW)) bus_c ();

    disparity_pace_mapper #(.X0(10), .X1(13), .Y0(5), .Y1(6), .MIN_COUNT(1)) u_a (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus_a));
    disparity_pace_mapper #(.X0(0), .X1(15), .Y0(0), .Y1(7), .MIN_COUNT(64)) u_b (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus_b));
    disparity_pace_mapper #(.X0(319), .X1(319), .Y0(239), .Y1(239), .MIN_COUNT(1)) u_c (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus_c));

    // Two-cycle BRAM model shared by all three instances.
    always @(posedge clk_in) begin
        a_p1          <= mem[bus_a.rd_addr_out];
        bus_a.disp_in <= a_p1;
        b_p1          <= mem[bus_b.rd_addr_out];
        bus_b.disp_in <= b_p1;
        c_p1          <= mem[bus_c.rd_addr_out];
        bus_c.disp_in <= c_p1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int mean, input int count, input int dv,
                                input int speed, input int c);
        exp_t e;
        e.mean = mean; e.count = count; e.dv = dv; e.speed = speed; e.cyc = c;
        return e;
    endfunction

    task automatic score(input string u, input exp_t e, input int mean, input int count,
                         input int dv, input int speed, input int busy);
        chk({u, " mean_disp"}, mean, e.mean);
        chk({u, " valid_count"}, count, e.count);
        chk({u, " depth_valid"}, dv, e.dv);
        chk({u, " speed"}, speed, e.speed);
        chk({u, " done_cycle"}, int'(cyc), e.cyc);
        chk({u, " busy_at_done"}, busy, 0);
    endtask

    task automatic unexpected(input string u);
        n_cmp++;
        n_bad++;
        $display("FAIL %s unexpected done_out: got 1, expected 0 (cycle %0d)", u, cyc);
    endtask

    always @(negedge clk_in) begin
        if (bus_a.done_out) begin
            if (q_a.size() == 0) unexpected("A");
            else score("A", q_a.pop_front(), int'(bus_a.mean_disp_out), int'(bus_a.valid_count_out),
                       int'(bus_a.depth_valid_out), int'(bus_a.speed_out), int'(bus_a.busy_out));
        end
        if (bus_b.done_out) begin
            if (q_b.size() == 0) unexpected("B");
            else score("B", q_b.pop_front(), int'(bus_b.mean_disp_out), int'(bus_b.valid_count_out),
                       int'(bus_b.depth_valid_out), int'(bus_b.speed_out), int'(bus_b.busy_out));
        end
        if (bus_c.done_out) begin
            if (q_c.size() == 0) unexpected("C");
            else score("C", q_c.pop_front(), int'(bus_c.mean_disp_out), int'(bus_c.valid_count_out),
                       int'(bus_c.depth_valid_out), int'(bus_c.speed_out), int'(bus_c.busy_out));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 76800; i++) mem[i] = 8'd0;
    endtask

    task automatic fill_roi(input int x0, input int x1, input int y0, input int y1, input int v);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                mem[y * 320 + x] = 8'(v);
    endtask

    // Start is sampled on the rising edge between the two negedges; t0 is that edge.
    task automatic pulse(input int u, output int t0);
        case (u)
            0:       bus_a.start_in = 1'b1;
            1:       bus_b.start_in = 1'b1;
            default: bus_c.start_in = 1'b1;
        endcase
        @(negedge clk_in);
        bus_a.start_in = 1'b0;
        bus_b.start_in = 1'b0;
        bus_c.start_in = 1'b0;
        t0 = int'(cyc);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && k < limit) begin
            @(negedge clk_in);
            k++;
        end
        if (k >= limit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done_out, expected one within %0d cycles", limit);
            q_a.delete(); q_b.delete(); q_c.delete();
        end
        tick(2);
    endtask

    task automatic pattern_mixed();
        clear_mem();
        mem[1610] = 8'd10; mem[1611] = 8'd11;
        mem[1930] = 8'd10; mem[1931] = 8'd11;
    endtask

    task automatic chk_zero_a();
        chk("A rst rd_addr", int'(bus_a.rd_addr_out), 0);
        chk("A rst busy", int'(bus_a.busy_out), 0);
        chk("A rst done", int'(bus_a.done_out), 0);
        chk("A rst mean", int'(bus_a.mean_disp_out), 0);
        chk("A rst count", int'(bus_a.valid_count_out), 0);
        chk("A rst depth_valid", int'(bus_a.depth_valid_out), 0);
        chk("A rst speed", int'(bus_a.speed_out), 0);
    endtask

    initial begin
        int t0;
        bus_a.start_in = 1'b0;
        bus_b.start_in = 1'b0;
        bus_c.start_in = 1'b0;
        clear_mem();
        tick(3);
        chk_zero_a();
        rst_in = 1'b0;
        tick(2);

        // Uniform ROI: addresses, mean and clamp-free speed.
        fill_roi(10, 13, 5, 6, 40);
        pulse(0, t0);
        q_a.push_back(mk(40, 8, 1, 2, t0 + 38));
        chk("A busy_after_start", int'(bus_a.busy_out), 1);
        for (int i = 0; i < 8; i++) begin
            chk("A rd_addr", int'(bus_a.rd_addr_out), (i < 4) ? 1610 + i : 1926 + i);
            @(negedge clk_in);
        end
        wait_idle(200);

        // Mixed/invalid pixels with a second start mid-scan that must be ignored.
        pattern_mixed();
        pulse(0, t0);
        q_a.push_back(mk(10, 4, 1, 1, t0 + 38));
        tick(3);
        pulse(0, t0);
        wait_idle(200);
        tick(45);

        // MIN_COUNT boundary on a 16x8 ROI: 128 valid, then 63 (held speed), then 64.
        clear_mem();
        fill_roi(0, 15, 0, 7, 192);
        pulse(1, t0);
        q_b.push_back(mk(192, 128, 1, 12, t0 + 158));
        wait_idle(400);

        clear_mem();
        for (int i = 0; i < 63; i++) mem[(i / 16) * 320 + (i % 16)] = 8'd200;
        pulse(1, t0);
        q_b.push_back(mk(0, 63, 0, 12, t0 + 158));
        wait_idle(400);

        clear_mem();
        for (int i = 0; i < 64; i++) mem[(i / 16) * 320 + (i % 16)] = 8'd17;
        pulse(1, t0);
        q_b.push_back(mk(17, 64, 1, 1, t0 + 158));
        wait_idle(400);

        // Single-pixel ROI at the last map address.
        clear_mem();
        mem[76799] = 8'd255;
        pulse(2, t0);
        chk("C rd_addr", int'(bus_c.rd_addr_out), 76799);
        q_c.push_back(mk(255, 1, 1, 15, t0 + 31));
        wait_idle(200);

        // Reset in the middle of DIVIDE, then a clean frame.
        fill_roi(10, 13, 5, 6, 40);
        pulse(0, t0);
        tick(20);
        rst_in = 1'b1;
        #1;
        chk_zero_a();
        tick(2);
        rst_in = 1'b0;
        tick(2);
        pattern_mixed();
        pulse(0, t0);
        q_a.push_back(mk(10, 4, 1, 1, t0 + 38));
        wait_idle(200);
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
